mmio_io_responder: RTL and testbench

Device-side responder for the processor's memory-mapped I/O window. Decodes the status word at 0xFFFF8000 and the device data word at 0xFFFF8004 on the processor data bus. Buffers received bytes from an external byte source in a small RX FIFO and forwards written bytes to an external byte sink through a one-entry TX holding register. It is the slave end of the status/data polling protocol that the processor-side address monitor drives.

---
 rtl/mmio_io_responder_pkg.sv | 65 ++++++
 rtl/mmio_io_responder_rx_fifo.sv | 60 ++++++
 rtl/mmio_io_responder.sv | 116 +++++++++++
 tb/tb_mmio_io_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_io_responder_pkg.sv
// Shared constants, access decode and status packing for the MMIO I/O responder.
package mmio_io_responder_pkg;

   localparam logic [31:0] STATUS_ADDR_DEF = 32'hFFFF_8000;
   localparam logic [31:0] DATA_ADDR_DEF   = 32'hFFFF_8004;

   localparam int RX_AVAIL = 0;
   localparam int TX_BUSY  = 1;
   localparam int RX_OVF   = 2;
   localparam int TX_DROP  = 3;

   typedef enum logic [2:0] {
      ACC_IDLE        = 3'd0,
      ACC_STATUS_RD   = 3'd1,
      ACC_DATA_RD     = 3'd2,
      ACC_UNMAPPED_RD = 3'd3,
      ACC_DATA_WR     = 3'd4,
      ACC_IGNORED_WR  = 3'd5
   } access_t;

   // A read strobe always wins; a simultaneous write is discarded.
   function automatic access_t decode_access(
      input logic [31:0] address,
      input logic        re,
      input logic        we,
      input logic [31:0] status_addr,
      input logic [31:0] data_addr
   );
      access_t acc;
      if (re) begin
         if (address == status_addr) begin
            acc = ACC_STATUS_RD;
         end else if (address == data_addr) begin
            acc = ACC_DATA_RD;
         end else begin
            acc = ACC_UNMAPPED_RD;
         end
      end else if (we) begin
         if (address == data_addr) begin
            acc = ACC_DATA_WR;
         end else begin
            acc = ACC_IGNORED_WR;
         end
      end else begin
         acc = ACC_IDLE;
      end
      return acc;
   endfunction

   function automatic logic [31:0] pack_status(
      input logic rx_avail,
      input logic tx_busy,
      input logic rx_ovf,
      input logic tx_drop
   );
      logic [31:0] word;
      word           = 32'd0;
      word[RX_AVAIL] = rx_avail;
      word[TX_BUSY]  = tx_busy;
      word[RX_OVF]   = rx_ovf;
      word[TX_DROP]  = tx_drop;
      return word;
   endfunction

endpackage

// File: rtl/mmio_io_responder_rx_fifo.sv
// Byte-wide synchronous FIFO with a combinational head output.
module io_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   // Qualify requests against the current occupancy and expose the head entry.
   always_comb begin
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
      dout      = mem_r[rptr_r];
   end

   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'd0;
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wptr_r] <= din;
            wptr_r        <= wptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mmio_io_responder.sv
// MMIO status/data responder: address decode, RX FIFO, TX holding register, sticky flags.
module mmio_io_responder
   import mmio_io_responder_pkg::*;
#(
   parameter int          RX_DEPTH    = 4,
   parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
   parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   access_t     access_s;
   logic [31:0] status_s;
   logic        push_s;
   logic        pop_s;
   logic [7:0]  fifo_dout_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        rx_ovf_set_s;
   logic        wr_accept_s;
   logic        wr_drop_s;
   logic        tx_drain_s;
   logic        status_rd_s;
   logic        rx_ovf_r;
   logic        tx_drop_r;
   logic        unused_wdata_s;

   assign unused_wdata_s = ^wdata[31:8];
   assign rx_ready       = ~fifo_full_s;

   // Decode the bus access and derive the per-cycle control strobes.
   always_comb begin
      access_s     = decode_access(address, re, we, STATUS_ADDR, DATA_ADDR);
      status_s     = pack_status(~fifo_empty_s, tx_valid, rx_ovf_r, tx_drop_r);
      status_rd_s  = (access_s == ACC_STATUS_RD);
      push_s       = rx_valid & ~fifo_full_s;
      pop_s        = (access_s == ACC_DATA_RD) & ~fifo_empty_s;
      rx_ovf_set_s = rx_valid & fifo_full_s;
      if (access_s == ACC_DATA_WR) begin
         wr_accept_s = ~tx_valid | tx_ready;
         wr_drop_s   = tx_valid & ~tx_ready;
      end else begin
         wr_accept_s = 1'b0;
         wr_drop_s   = 1'b0;
      end
      tx_drain_s = tx_valid & tx_ready & ~wr_accept_s;
   end

   io_rx_fifo #(
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (rx_data),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Read data register: loaded only on a read strobe, held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= 32'd0;
      end else begin
         case (access_s)
            ACC_STATUS_RD:   rdata <= status_s;
            ACC_DATA_RD:     rdata <= fifo_empty_s ? 32'd0 : {24'd0, fifo_dout_s};
            ACC_UNMAPPED_RD: rdata <= 32'd0;
            default:         rdata <= rdata;
         endcase
      end
   end

   // Sticky flags: a fresh set in the same cycle as a status read survives the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_ovf_r  <= 1'b0;
         tx_drop_r <= 1'b0;
      end else begin
         rx_ovf_r  <= rx_ovf_set_s | (rx_ovf_r & ~status_rd_s);
         tx_drop_r <= wr_drop_s | (tx_drop_r & ~status_rd_s);
      end
   end

   // One-entry TX holding register.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_data  <= 8'd0;
         tx_valid <= 1'b0;
      end else if (wr_accept_s) begin
         tx_data  <= wdata[7:0];
         tx_valid <= 1'b1;
      end else if (tx_drain_s) begin
         tx_data  <= tx_data;
         tx_valid <= 1'b0;
      end else begin
         tx_data  <= tx_data;
         tx_valid <= tx_valid;
      end
   end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for mmio_io_responder: reads queue expected rdata, a monitor compares.
module tb_mmio_io_responder;

   localparam logic [31:0] SA = 32'hFFFF_8000;
   localparam logic [31:0] DA = 32'hFFFF_8004;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address = 32'd0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] exp_q [$];
   string       name_q [$];
   logic        rd_pending = 1'b0;

   mmio_io_responder dut (
      .clk      (clk),
      .reset    (reset),
      .address  (address),
      .we       (we),
      .re       (re),
      .wdata    (wdata),
      .rdata    (rdata),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Remember whether a read was sampled so the monitor knows rdata is due.
   always @(posedge clk) rd_pending <= re & ~reset;

   always @(negedge clk) begin
      if (rd_pending) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_read: got %h expected none queued", rdata);
         end else begin
            chk(name_q.pop_front(), rdata, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      address = a; re = 1'b1;
      exp_q.push_back(exp); name_q.push_back(nm);
      tick();
      re = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      address = a; wdata = {24'hABCDEF, d}; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      reset = 1'b0;
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
      rd("status_after_reset", SA, 32'h0);

      push(8'h41); push(8'h42);
      rd("data_0x41", DA, 32'h41);
      rd("data_0x42", DA, 32'h42);
      rd("status_empty", SA, 32'h0);

      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      chk("full_rx_ready", {31'd0, rx_ready}, 32'd0);
      push(8'h14);
      rd("status_ovf", SA, 32'h5);
      for (int i = 0; i < 4; i++) rd("data_drain", DA, 32'h10 + 32'(i));
      rd("status_ovf_cleared", SA, 32'h0);

      tx_ready = 1'b0;
      wr(DA, 8'h55);
      chk("tx_valid_set", {31'd0, tx_valid}, 32'd1);
      chk("tx_data_55", {24'd0, tx_data}, 32'h55);
      wr(DA, 8'hAA);
      chk("tx_data_kept", {24'd0, tx_data}, 32'h55);
      rd("status_busy_drop", SA, 32'hA);
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      chk("tx_drained", {31'd0, tx_valid}, 32'd0);
      rd("status_drop_cleared", SA, 32'h0);

      wr(DA, 8'h66);
      tx_ready = 1'b1;
      wr(DA, 8'h77);
      tx_ready = 1'b0;
      chk("tx_replace_data", {24'd0, tx_data}, 32'h77);
      chk("tx_replace_valid", {31'd0, tx_valid}, 32'd1);
      rd("status_busy_only", SA, 32'h2);
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;

      address = DA; re = 1'b1; we = 1'b1; wdata = 32'h99;
      exp_q.push_back(32'h0); name_q.push_back("re_we_empty");
      tick();
      re = 1'b0; we = 1'b0;
      chk("re_we_no_tx", {31'd0, tx_valid}, 32'd0);
      wr(SA, 8'hFF);
      chk("status_write_no_tx", {31'd0, tx_valid}, 32'd0);
      rd("status_after_ignored_wr", SA, 32'h0);
      rd("unmapped_low", 32'h0000_1234, 32'h0);
      rd("unmapped_near", 32'hFFFF_8008, 32'h0);

      for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
      address = DA; re = 1'b1; rx_data = 8'h24; rx_valid = 1'b1;
      exp_q.push_back(32'h20); name_q.push_back("full_pop");
      tick();
      re = 1'b0;
      chk("after_pop_ready", {31'd0, rx_ready}, 32'd1);
      tick();
      rx_valid = 1'b0;
      chk("after_push_full", {31'd0, rx_ready}, 32'd0);
      rd("status_full_pop_ovf", SA, 32'h5);
      for (int i = 1; i < 5; i++) rd("full_pop_drain", DA, 32'h20 + 32'(i));
      rd("status_drained", SA, 32'h0);

      push(8'h30);
      address = DA; re = 1'b1; rx_data = 8'h31; rx_valid = 1'b1;
      exp_q.push_back(32'h30); name_q.push_back("one_entry_pop");
      tick();
      re = 1'b0; rx_valid = 1'b0;
      rd("status_count_one", SA, 32'h1);
      rd("one_entry_next", DA, 32'h31);
      rd("status_one_empty", SA, 32'h0);

      push(8'h01); push(8'h02); push(8'h03);
      rd("status_before_reset", SA, 32'h1);
      wr(DA, 8'h77);
      chk("pre_reset_tx_valid", {31'd0, tx_valid}, 32'd1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_reset_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("mid_reset_tx_data", {24'd0, tx_data}, 32'd0);
      chk("mid_reset_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("mid_reset_rdata", rdata, 32'd0);
      rd("data_after_reset", DA, 32'h0);
      rd("status_after_mid_reset", SA, 32'h0);

      tick(); tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
